// File: rtl/ber_sync_ctrl_pkg.sv
// Shared types and constants for the BER sync controller.
// Holds the FSM state encoding, offset/window widths and the min-error start value.
package ber_sync_ctrl_pkg;

   localparam int OFF_W  = 9;
   localparam int WCNT_W = 10;

   localparam logic [WCNT_W-1:0] MIN_ERR_INIT = 10'd1023;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_SWEEP = 3'd2,
      ST_SLIP  = 3'd3,
      ST_ALIGN = 3'd4,
      ST_COUNT = 3'd5
   } state_t;

endpackage

// File: rtl/ber_sync_ctrl_sat_cnt.sv
// ber_sat_cnt32: 32-bit up-counter that sticks at all-ones.
// Counts when both en and inc are high; clr has priority over counting.
module ber_sat_cnt32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic        inc,
   output logic [31:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && inc && (cnt != '1)) begin
         cnt <= cnt + 32'd1;
      end
   end

endmodule

// File: rtl/ber_sync_ctrl.sv
// ber_sync_ctrl: sweeps every PRBS offset, picks the one with fewest errors, then counts BER.
// Loss-of-lock detection in COUNT is built only when BER_SYNC_LOL_EN is defined.
//
// state | meaning
// IDLE  | waiting for i_start
// WAIT  | start-up delay, START_DLY enabled cycles
// SWEEP | one PRBS_LEN-bit error window at the current offset
// SLIP  | hold the local PRBS one bit, step the offset
// ALIGN | hold the local PRBS o_best_off bits to land on the best offset
// COUNT | locked, accumulating bit and error counts
module ber_sync_ctrl
   import ber_sync_ctrl_pkg::*;
#(
   parameter int PRBS_LEN  = 511,
   parameter int START_DLY = 352590,
   parameter int LOL_THR   = 64
) (
   input  logic              clk,
   input  logic              i_reset,
   input  logic              i_en,
   input  logic              i_start,
   input  logic              i_err,
   output logic              o_prbs_adv,
   output logic              o_locked,
   output logic [OFF_W-1:0]  o_best_off,
   output logic [WCNT_W-1:0] o_min_err,
   output logic [31:0]       o_bit_cnt,
   output logic [31:0]       o_err_cnt,
   output logic              o_lol
);

   localparam logic [31:0]  DLY_LOAD = (START_DLY > 0) ? 32'(START_DLY - 1) : 32'd0;
   localparam logic [31:0]  WIN_LOAD = 32'(PRBS_LEN - 1);
   localparam logic [OFF_W:0] LEN_C  = (OFF_W + 1)'(PRBS_LEN);

   state_t              state, state_nxt;
   logic [31:0]         tmr, tmr_nxt;
   logic [OFF_W-1:0]    offset, off_nxt;
   logic [OFF_W-1:0]    best_off, best_nxt;
   logic [WCNT_W-1:0]   min_err, min_nxt;
   logic [WCNT_W-1:0]   win_cnt, win_nxt;
   logic [WCNT_W-1:0]   win_sum;
   logic [OFF_W:0]      off_inc;
   logic                prbs_adv;
   logic                cnt_clr;
   logic                cnt_run;

`ifdef BER_SYNC_LOL_EN
   localparam logic [WCNT_W-1:0] LOL_C = WCNT_W'(LOL_THR);
   logic                lol;
`endif

   assign win_sum = win_cnt + WCNT_W'(i_err);
   assign off_inc = {1'b0, offset} + (OFF_W + 1)'(1);

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         state    <= ST_IDLE;
         tmr      <= '0;
         offset   <= '0;
         best_off <= '0;
         min_err  <= MIN_ERR_INIT;
         win_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         tmr      <= tmr_nxt;
         offset   <= off_nxt;
         best_off <= best_nxt;
         min_err  <= min_nxt;
         win_cnt  <= win_nxt;
      end
   end

   // Nothing moves unless i_en is high, so every branch below sits under it.
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      off_nxt   = offset;
      best_nxt  = best_off;
      min_nxt   = min_err;
      win_nxt   = win_cnt;
      prbs_adv  = 1'b0;
      cnt_clr   = 1'b0;
      cnt_run   = 1'b0;
`ifdef BER_SYNC_LOL_EN
      lol       = 1'b0;
`endif
      if (i_en) begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state_nxt = ST_WAIT;
                  tmr_nxt   = DLY_LOAD;
                  off_nxt   = '0;
                  best_nxt  = '0;
                  win_nxt   = '0;
                  min_nxt   = MIN_ERR_INIT;
                  cnt_clr   = 1'b1;
               end
            end
            ST_WAIT: begin
               if (tmr == '0) begin
                  state_nxt = ST_SWEEP;
                  tmr_nxt   = WIN_LOAD;
                  off_nxt   = '0;
               end else begin
                  tmr_nxt = tmr - 32'd1;
               end
            end
            ST_SWEEP: begin
               prbs_adv = 1'b1;
               win_nxt  = win_sum;
               if (tmr == '0) begin
                  // strict compare keeps the lowest offset on ties
                  if (win_sum < min_err) begin
                     min_nxt  = win_sum;
                     best_nxt = offset;
                  end
                  win_nxt   = '0;
                  state_nxt = ST_SLIP;
               end else begin
                  tmr_nxt = tmr - 32'd1;
               end
            end
            ST_SLIP: begin
               off_nxt = off_inc[OFF_W-1:0];
               if (off_inc < LEN_C) begin
                  state_nxt = ST_SWEEP;
                  tmr_nxt   = WIN_LOAD;
               end else begin
                  state_nxt = ST_ALIGN;
                  tmr_nxt   = 32'(best_off);
               end
            end
            ST_ALIGN: begin
               // best offset 0 still spends one hold cycle here
               if (tmr <= 32'd1) begin
                  state_nxt = ST_COUNT;
                  tmr_nxt   = WIN_LOAD;
                  win_nxt   = '0;
               end else begin
                  tmr_nxt = tmr - 32'd1;
               end
            end
            ST_COUNT: begin
               prbs_adv = 1'b1;
               cnt_run  = 1'b1;
`ifdef BER_SYNC_LOL_EN
               win_nxt  = win_sum;
               if (tmr == '0) begin
                  tmr_nxt = WIN_LOAD;
                  win_nxt = '0;
                  if (win_sum > LOL_C) begin
                     lol       = 1'b1;
                     state_nxt = ST_SWEEP;
                     off_nxt   = '0;
                     min_nxt   = MIN_ERR_INIT;
                  end
               end else begin
                  tmr_nxt = tmr - 32'd1;
               end
`endif
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   ber_sat_cnt32 u_bit_cnt (
      .clk   (clk),
      .rst_n (i_reset),
      .clr   (cnt_clr),
      .en    (cnt_run),
      .inc   (1'b1),
      .cnt   (o_bit_cnt)
   );

   ber_sat_cnt32 u_err_cnt (
      .clk   (clk),
      .rst_n (i_reset),
      .clr   (cnt_clr),
      .en    (cnt_run),
      .inc   (i_err),
      .cnt   (o_err_cnt)
   );

   assign o_prbs_adv = prbs_adv;
   assign o_locked   = (state == ST_COUNT);
   assign o_best_off = best_off;
   assign o_min_err  = min_err;

`ifdef BER_SYNC_LOL_EN
   assign o_lol = lol;
`else
   assign o_lol = 1'b0;
`endif

endmodule
